// File: rtl/lfsr_prbs_gen.sv
// Fibonacci LFSR PRBS generator / self-synchronising checker with lock
// detection and a saturating error counter.
module lfsr_prbs_gen #(
    parameter int               WIDTH    = 22,
    parameter logic [WIDTH-1:0] TAPS     = 22'h300000,
    parameter logic [WIDTH-1:0] SEED     = 22'h3FFFFF,
    parameter int               LOCK_CNT = 22,
    parameter int               LOSS_CNT = 8,
    parameter int               ERR_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_in_i,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             rx_bit_i,
    input  logic             err_clr_i,
    output logic [WIDTH-1:0] out_o,
    output logic             bit_out_o,
    output logic             locked_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } fsm_e;

    logic [WIDTH-1:0] state_q, state_d;
    logic             bit_q, bit_d;
    fsm_e             fsm_q, fsm_d;
    logic [MW-1:0]    match_q, match_d;
    logic [LW-1:0]    miss_q, miss_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             mode_q;

    logic fb;
    logic mode_chg;
    logic err_inc;

    assign fb       = ^(state_q & TAPS);
    assign mode_chg = mode_i ^ mode_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEED;
            bit_q   <= 1'b0;
            fsm_q   <= HUNT;
            match_q <= '0;
            miss_q  <= '0;
            err_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            fsm_q   <= fsm_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            mode_q  <= mode_i;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        fsm_d   = fsm_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_inc = 1'b0;

        if (load_i) begin
            // An all-zero seed would lock the register up, so fall back to SEED.
            state_d = (seed_in_i == '0) ? SEED : seed_in_i;
            fsm_d   = HUNT;
            match_d = '0;
            miss_d  = '0;
        end else if (en_i) begin
            if (!mode_i) begin
                state_d = {state_q[WIDTH-2:0], fb};
                bit_d   = fb;
                fsm_d   = HUNT;
                match_d = '0;
                miss_d  = '0;
            end else if (fsm_q == HUNT) begin
                // Shifting in the received bit lets the register self-synchronise.
                state_d = {state_q[WIDTH-2:0], rx_bit_i};
                bit_d   = rx_bit_i;
                miss_d  = '0;
                if (rx_bit_i == fb) begin
                    if (match_q == LOCK_LAST) begin
                        fsm_d   = LOCKED;
                        match_d = '0;
                    end else begin
                        match_d = match_q + MW'(1);
                    end
                end else begin
                    match_d = '0;
                end
            end else begin
                state_d = {state_q[WIDTH-2:0], fb};
                bit_d   = fb;
                if (rx_bit_i != fb) begin
                    err_inc = 1'b1;
                    if (miss_q == LOSS_LAST) begin
                        fsm_d   = HUNT;
                        miss_d  = '0;
                        match_d = '0;
                    end else begin
                        miss_d = miss_q + LW'(1);
                    end
                end else begin
                    miss_d = '0;
                end
            end
        end

        // A mode toggle restarts acquisition regardless of load or enable.
        if (mode_chg) begin
            fsm_d   = HUNT;
            match_d = '0;
            miss_d  = '0;
            err_inc = 1'b0;
        end
    end

    always_comb begin
        err_d = err_q;
        if (err_clr_i) begin
            err_d = '0;
        end else if (err_inc && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    assign out_o     = state_q;
    assign bit_out_o = bit_q;
    assign locked_o  = (fsm_q == LOCKED);
    assign err_cnt_o = err_q;

endmodule
